// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter.
//   state_e  : arbiter FSM states (IDLE = arbitration cycle, BURST = granted).
//   MAX_REQ  : widest request vector the round-robin helper can search.
//   RR_IDX_W : width of the index returned by next_rr (grant-id width).
//   next_rr  : round-robin winner search starting just above 'last'.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int MAX_REQ  = 32;
    localparam int RR_IDX_W = $clog2(MAX_REQ);

    // Returns the first set request bit found searching upward from last+1,
    // wrapping at num_req. Returns 0 when no request is set (callers qualify
    // the result with their own any-request flag). The loop is bounded by the
    // constant MAX_REQ so it unrolls to a fixed priority network.
    function automatic logic [RR_IDX_W-1:0] next_rr(
        input logic [MAX_REQ-1:0]  req,
        input logic [RR_IDX_W-1:0] last,
        input int unsigned         num_req
    );
        logic [RR_IDX_W-1:0] win;
        logic [RR_IDX_W-1:0] idx_w;
        logic                found;
        int unsigned         idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= num_req) begin
                idx   = (32'(last) + k) % num_req;
                idx_w = idx[RR_IDX_W-1:0];
                if (!found && req[idx_w]) begin
                    win   = idx_w;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin priority selector.
//   req        : request bits, one per requester.
//   last_grant : requester granted most recently (lowest priority now).
//   winner     : first requester above last_grant with req set (wraps).
//   any_req    : at least one request bit is set; qualifies winner.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      winner,
    output logic               any_req
);

    // Zero-extend the request vector to the helper's fixed search width.
    logic [MAX_REQ-1:0] req_ext;

    generate
        for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_ext
            if (gi < NUM_REQ) begin : g_live
                assign req_ext[gi] = req[gi];
            end else begin : g_pad
                assign req_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign winner  = GW'(next_rr(req_ext, RR_IDX_W'(last_grant), NUM_REQ));
    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the FIFO write port between NUM_REQ requesters.
// A requester is granted for a burst of at most MAX_BURST words; each word is
// acknowledged combinationally and written to the FIFO one cycle later through
// registered wr_en/data_in. The FIFO avail count is used as write credit, with
// one slot reserved for a write already in flight.
//   wr_clk, wr_rst : write clock, asynchronous active-low reset.
//   req, req_data  : per-requester word valid and packed words.
//   ack            : one-hot, word on the granted slice consumed this cycle.
//   FIFO_full/avail: FIFO status used as credit.
//   wr_en, data_in : registered FIFO write strobe and data.
//   grant_id, busy : current/last grant, high while a burst is open.
//   stall_cnt      : saturating count of blocked grant cycles.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          FIFO_full,
    input  logic [ADDR_WIDTH:0]           avail,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [15:0]                   stall_cnt
);

    localparam int GW  = $clog2(NUM_REQ);
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int AVW = ADDR_WIDTH + 1;

    state_e                state_reg,      state_next;
    logic [GW-1:0]         grant_id_reg,   grant_id_next;
    logic [GW-1:0]         last_grant_reg, last_grant_next;
    logic [BW-1:0]         beat_reg,       beat_next;
    logic                  wr_en_reg,      wr_en_next;
    logic [DATA_WIDTH-1:0] data_in_reg,    data_in_next;
    logic [15:0]           stall_cnt_reg,  stall_cnt_next;

    logic [GW-1:0]         winner;
    logic                  any_req;
    logic                  req_g;
    logic                  credit_ok;
    logic                  accept;
    logic [DATA_WIDTH-1:0] slice_data [NUM_REQ];
    logic [DATA_WIDTH-1:0] sel_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_picker (
        .req        (req),
        .last_grant (last_grant_reg),
        .winner     (winner),
        .any_req    (any_req)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign slice_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign ack[gi]        = accept && (grant_id_reg == GW'(gi));
        end
    endgenerate

    assign req_g    = req[grant_id_reg];
    assign sel_data = slice_data[grant_id_reg];

    // A write in flight (wr_en_reg) is not yet reflected in avail, so it
    // must be counted against the free slots before accepting another word.
    assign credit_ok = !FIFO_full && (avail > AVW'(wr_en_reg));
    assign accept    = (state_reg == BURST) && req_g && credit_ok;

    always_comb begin
        state_next      = state_reg;
        grant_id_next   = grant_id_reg;
        last_grant_next = last_grant_reg;
        beat_next       = beat_reg;
        wr_en_next      = 1'b0;
        data_in_next    = data_in_reg;
        stall_cnt_next  = stall_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_id_next = winner;
                    beat_next     = '0;
                    state_next    = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    wr_en_next   = 1'b1;
                    data_in_next = sel_data;
                    beat_next    = beat_reg + BW'(1);
                    if (beat_reg == BW'(MAX_BURST - 1)) begin
                        last_grant_next = grant_id_reg;
                        state_next      = IDLE;
                    end
                end else if (!req_g) begin
                    // Requester went quiet (possibly while blocked): close the burst.
                    last_grant_next = grant_id_reg;
                    state_next      = IDLE;
                end else if (stall_cnt_reg != 16'hFFFF) begin
                    stall_cnt_next = stall_cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_reg      <= IDLE;
            grant_id_reg   <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
            beat_reg       <= '0;
            wr_en_reg      <= 1'b0;
            data_in_reg    <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            grant_id_reg   <= grant_id_next;
            last_grant_reg <= last_grant_next;
            beat_reg       <= beat_next;
            wr_en_reg      <= wr_en_next;
            data_in_reg    <= data_in_next;
            stall_cnt_reg  <= stall_cnt_next;
        end
    end

    assign wr_en     = wr_en_reg;
    assign data_in   = data_in_reg;
    assign grant_id  = grant_id_reg;
    assign busy      = (state_reg == BURST);
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Directed scenarios followed by randomized traffic against a FIFO model.
// A cycle reference model (owner/beats/in-flight bookkeeping with modulo
// round-robin search) predicts every output; a queue of acked words checks
// the FIFO write stream.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int GW = 2;
    localparam int DEPTH = 1 << AW;

    logic              wr_clk = 1'b0;
    logic              wr_rst = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      ack;
    logic              FIFO_full = 1'b0;
    logic [AW:0]       avail = 6'd32;
    logic              wr_en;
    logic [DW-1:0]     data_in;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic [15:0]       stall_cnt;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (N),
        .MAX_BURST  (MB)
    ) dut (
        .wr_clk    (wr_clk),
        .wr_rst    (wr_rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .FIFO_full (FIFO_full),
        .avail     (avail),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .grant_id  (grant_id),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    int          m_owner;      // -1 when no burst is open
    int          m_last;
    int          m_beats;
    int          m_stall;
    bit          m_inflight;
    logic [DW-1:0] exp_q[$];
    int          wr_count;
    int          ack_cnt [N];
    int          grant_log[$];
    bit          prev_busy;
    logic [N-1:0] last_ack;
    bit          fifo_mode = 0;
    int          fifo_cnt = 0;
    int          rd_pct = 40;

    task automatic reset_model();
        m_owner    = -1;
        m_last     = N - 1;
        m_beats    = 0;
        m_stall    = 0;
        m_inflight = 0;
        exp_q.delete();
        prev_busy  = 0;
        fifo_cnt   = 0;
    endtask

    task automatic set_word(input int i, input logic [DW-1:0] w);
        req_data[i*DW +: DW] = w;
    endtask

    function automatic logic [DW-1:0] word_of(input int i);
        logic [N*DW-1:0] sh;
        sh = req_data >> (i * DW);
        return sh[DW-1:0];
    endfunction

    // One clock cycle: compare at the falling edge, advance the model, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic step();
        bit          acc;
        int          idx;
        bit          found;
        logic [31:0] exp_ack;
        @(negedge wr_clk);
        check("busy",      32'(busy),      32'(m_owner >= 0));
        check("wr_en",     32'(wr_en),     32'(m_inflight));
        check("stall_cnt", 32'(stall_cnt), m_stall);
        if (m_owner >= 0) check("grant_id", 32'(grant_id), m_owner);
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        prev_busy = busy;
        if (wr_en) begin
            wr_count++;
            check("wr_while_full", 32'(FIFO_full), 0);
            if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
            else                   check("data_in", 32'(data_in), 32'(exp_q.pop_front()));
        end
        acc = (m_owner >= 0) && req[m_owner[1:0]] && !FIFO_full && (int'(avail) > int'(m_inflight));
        exp_ack = acc ? (32'd1 << m_owner) : 32'd0;
        check("ack", 32'(ack), exp_ack);
        last_ack = ack;
        for (int i = 0; i < N; i++) if (ack[i[1:0]]) ack_cnt[i]++;
        if (fifo_mode) begin
            fifo_cnt += int'(wr_en);
            if (fifo_cnt > 0 && $urandom_range(99) < rd_pct) fifo_cnt--;
        end
        if (m_owner < 0) begin
            m_inflight = 0;
            if (req != '0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (!found && req[idx[1:0]]) begin
                        m_owner = idx;
                        found   = 1;
                    end
                end
                m_beats = 0;
            end
        end else begin
            m_inflight = acc;
            if (acc) begin
                exp_q.push_back(word_of(m_owner));
                m_beats++;
                if (m_beats == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else if (!req[m_owner[1:0]]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_stall < 65535) begin
                m_stall++;
            end
        end
        @(posedge wr_clk);
        #1;
        if (fifo_mode) begin
            avail     = (AW+1)'(DEPTH - fifo_cnt);
            FIFO_full = (fifo_cnt >= DEPTH);
        end
    endtask

    task automatic do_reset();
        wr_rst = 1'b0;
        #1;
        reset_model();
        #1;
        wr_rst = 1'b1;
    endtask

    int s0;
    int w0;
    int a0;

    initial begin
        reset_model();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        wr_count = 0;
        #12;
        check("rst_wr_en",    32'(wr_en),     0);
        check("rst_data_in",  32'(data_in),   0);
        check("rst_ack",      32'(ack),       0);
        check("rst_busy",     32'(busy),      0);
        check("rst_grant_id", 32'(grant_id),  0);
        check("rst_stall",    32'(stall_cnt), 0);
        @(posedge wr_clk);
        #1;
        wr_rst = 1'b1;

        // 1: single requester, full burst then re-grant after one idle cycle
        set_word(0, 8'hA5);
        req = 4'b0001;
        wr_count = 0;
        a0 = ack_cnt[0];
        repeat (6) step();
        check("t1_writes", wr_count, 4);
        check("t1_acks", ack_cnt[0] - a0, 4);
        step();
        check("t1_regrant_busy", 32'(busy), 1);
        check("t1_regrant_id", 32'(grant_id), 0);
        req = '0;
        repeat (3) step();

        // 2: all requesting, rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_word(i, 8'(8'h10 + i));
        req = 4'b1111;
        grant_log.delete();
        wr_count = 0;
        repeat (22) step();
        check("t2_writes_round", wr_count, 16);
        check("t2_grants", grant_log.size(), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check($sformatf("t2_grant%0d", k), grant_log[k], k % N);
        req = '0;
        repeat (3) step();

        // 3: low credit with a write in flight
        do_reset();
        set_word(1, 8'h3C);
        req = 4'b0010;
        avail = 6'd32;
        a0 = ack_cnt[1];
        step();
        step();
        s0 = int'(stall_cnt);
        avail = 6'd1;
        repeat (4) step();
        avail = 6'd3;
        step();
        req = '0;
        repeat (3) step();
        avail = 6'd32;
        check("t3_beats", ack_cnt[1] - a0, 4);
        check("t3_stalls", int'(stall_cnt) - s0, 2);

        // 4: FIFO full at the start of requester 2's burst
        set_word(2, 8'h5A);
        req = 4'b0100;
        FIFO_full = 1'b1;
        s0 = int'(stall_cnt);
        a0 = ack_cnt[2];
        step();
        repeat (3) step();
        check("t4_no_ack_full", ack_cnt[2] - a0, 0);
        FIFO_full = 1'b0;
        repeat (4) step();
        req = '0;
        repeat (3) step();
        check("t4_stalls", int'(stall_cnt) - s0, 3);
        check("t4_beats", ack_cnt[2] - a0, 4);

        // 5: requester 2 drops after two beats, requester 3 waiting
        do_reset();
        set_word(2, 8'h77);
        set_word(3, 8'h88);
        req = 4'b1100;
        w0 = wr_count;
        step();
        step();
        set_word(2, 8'h78);
        step();
        req = 4'b1000;
        step();
        step();
        check("t5_writes", wr_count - w0, 2);
        step();
        check("t5_next_grant", 32'(grant_id), 3);
        req = '0;
        repeat (6) step();

        // 6: asynchronous reset mid-burst
        set_word(0, 8'hC3);
        req = 4'b0001;
        step();
        step();
        step();
        #1;
        check("t6_pre_ack", 32'(ack), 1);
        wr_rst = 1'b0;
        #1;
        check("t6_rst_wr_en", 32'(wr_en), 0);
        check("t6_rst_ack",   32'(ack),   0);
        check("t6_rst_busy",  32'(busy),  0);
        reset_model();
        set_word(1, 8'h11);
        set_word(3, 8'h33);
        req = 4'b1010;
        grant_log.delete();
        #1;
        wr_rst = 1'b1;
        step();
        step();
        check("t6_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
        req = '0;
        repeat (6) step();

        // Randomized traffic against a FIFO occupancy model
        do_reset();
        fifo_mode = 1;
        avail = 6'd32;
        FIFO_full = 1'b0;
        last_ack = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) rd_pct = 15;
            for (int i = 0; i < N; i++) begin
                if (req[i[1:0]] && last_ack[i[1:0]]) begin
                    set_word(i, 8'($urandom));
                    req[i[1:0]] = ($urandom_range(99) < 70);
                end else if (!req[i[1:0]]) begin
                    set_word(i, 8'($urandom));
                    req[i[1:0]] = ($urandom_range(99) < 30);
                end else if ($urandom_range(99) < 3) begin
                    req[i[1:0]] = 1'b0;
                end
            end
            step();
        end
        req = '0;
        rd_pct = 100;
        repeat (6) step();
        check("rand_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
